// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared types and command defaults for the SPI memory arbiter
package spi_mem_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  typedef enum logic {FETCH, DATA} port_t;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
endpackage

// File: rtl/spi_mem_arbiter_shifter.sv
// spi_byte_shifter: 8-bit SPI mode-0 shift engine, two clk cycles per bit
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       byte_done,
  output logic [7:0] dout,
  output logic       sclk,
  output logic       mosi
);
  logic       active;
  logic       phase;
  logic [2:0] cnt;
  logic [7:0] tx;
  // byte_done marks the final phase so the next start reloads without a gap
  assign byte_done = active & phase & (cnt == 3'd7);
  assign sclk = active & phase;
  assign mosi = active ? tx[7] : start & din[7];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active <= 1'b0;
      phase <= 1'b0;
      cnt <= 3'd0;
      tx <= 8'h00;
      dout <= 8'h00;
    end else begin
      if (active & phase) dout <= {dout[6:0], miso};
      if (start) begin
        active <= 1'b1;
        phase <= 1'b0;
        cnt <= 3'd0;
        tx <= din;
      end else if (active) begin
        phase <= ~phase;
        if (phase) begin
          tx <= {tx[6:0], 1'b0};
          cnt <= cnt + 3'd1;
        end
        if (byte_done) active <= 1'b0;
      end
    end
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: round-robin fetch/data arbiter sequencing single-byte SPI memory frames
module spi_mem_arbiter #(
  parameter int         ADDR_BYTES = 3,
  parameter logic [7:0] CMD_READ = spi_mem_pkg::CMD_READ,
  parameter logic [7:0] CMD_WRITE = spi_mem_pkg::CMD_WRITE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_rom_n,
  output logic        spi_cs_ram_n
);
  import spi_mem_pkg::*;
  localparam int AW = 8 * ADDR_BYTES;
  localparam int FW = AW + 16;
  localparam logic [2:0] LAST = 3'(ADDR_BYTES + 1);
  state_t          state, nxt;
  port_t           port, last_grant;
  logic            rd;
  logic [2:0]      bcnt;
  logic [FW-1:0]   fr;
  logic            start, byte_done, grant_f, req_any;
  logic [7:0]      rx;
  assign req_any = f_req | d_req;
  assign grant_f = f_req & (~d_req | last_grant == DATA);
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    start = 1'b0;
    case (state)
      IDLE: nxt = req_any ? SETUP : IDLE;
      SETUP: begin
        start = 1'b1;
        nxt = SHIFT;
      end
      SHIFT: if (byte_done) begin
        start = bcnt != LAST;
        nxt = bcnt == LAST ? HOLD : SHIFT;
      end
      HOLD: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // fr holds the whole frame; each byte start consumes its top byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      port <= FETCH;
      last_grant <= DATA;
      rd <= 1'b0;
      bcnt <= 3'd0;
      fr <= '0;
      spi_cs_rom_n <= 1'b1;
      spi_cs_ram_n <= 1'b1;
      f_done <= 1'b0;
      d_done <= 1'b0;
      rdata <= 8'h00;
    end else begin
      f_done <= state == HOLD && port == FETCH;
      d_done <= state == HOLD && port == DATA;
      if (state == IDLE && req_any) begin
        port <= grant_f ? FETCH : DATA;
        last_grant <= grant_f ? FETCH : DATA;
        rd <= grant_f | ~d_we;
        bcnt <= 3'd0;
        fr <= grant_f ? {CMD_READ, AW'(f_addr), 8'h00}
                      : {d_we ? CMD_WRITE : CMD_READ, AW'(d_addr), d_we ? d_wdata : 8'h00};
        spi_cs_rom_n <= ~grant_f;
        spi_cs_ram_n <= grant_f;
      end
      if (start) fr <= fr << 8;
      if (state == SHIFT && start) bcnt <= bcnt + 3'd1;
      if (state == HOLD) begin
        spi_cs_rom_n <= 1'b1;
        spi_cs_ram_n <= 1'b1;
        if (rd) rdata <= rx;
      end
    end
  spi_byte_shifter u_shift (
    .clk(clk),
    .rst(rst),
    .start(start),
    .din(fr[FW-1 -: 8]),
    .miso(spi_miso),
    .byte_done(byte_done),
    .dout(rx),
    .sclk(spi_sclk),
    .mosi(spi_mosi)
  );
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: scoreboard bench with an SPI slave model for spi_mem_arbiter
module tb_spi_mem_arbiter;
  typedef struct {
    logic        rom;
    logic [39:0] bytes;
    logic [7:0]  resp;
    logic [7:0]  rdata;
  } frame_t;
  logic clk = 0, rst = 0, f_req = 0, d_req = 0, d_we = 0, spi_miso;
  logic [15:0] f_addr = 0, d_addr = 0;
  logic [7:0] d_wdata = 0;
  logic f_done, d_done, busy, spi_sclk, spi_mosi, spi_cs_rom_n, spi_cs_ram_n;
  logic [7:0] rdata;
  frame_t sb[$];
  frame_t e;
  int n_run = 0, n_fail = 0, cyc = 0, nb = 0, t_grant = 0, t_high = 0, nf = 0, nd = 0;
  bit inf = 0, have_high = 0, rom_sel = 0, pf = 0, pd = 0, glitch = 0;
  logic [39:0] bits = 0;
  logic [7:0] model_rd = 0;

  spi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_rom_n(spi_cs_rom_n), .spi_cs_ram_n(spi_cs_ram_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_f(input logic [15:0] a, input logic [7:0] resp);
    model_rd = resp;
    sb.push_back('{1'b1, {8'h03, 8'h00, a, 8'h00}, resp, resp});
  endtask

  task automatic exp_d(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] resp);
    if (!we) model_rd = resp;
    sb.push_back('{1'b0, {we ? 8'h02 : 8'h03, 8'h00, a, we ? wd : 8'h00}, resp, model_rd});
  endtask

  task automatic wait_done(input bit isf);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (isf ? f_done : d_done) return;
    end
    chk(isf ? "f_done_timeout" : "d_done_timeout", 0, 1);
  endtask

  task automatic wait_cs_rom;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!spi_cs_rom_n) return;
    end
    chk("cs_rom_timeout", 0, 1);
  endtask

  task automatic fetch(input logic [15:0] a);
    f_addr = a;
    f_req = 1;
    wait_done(1);
    f_req = 0;
  endtask

  task automatic dacc(input logic we, input logic [15:0] a, input logic [7:0] wd);
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1;
    wait_done(0);
    d_req = 0;
  endtask

  // SPI slave model and frame scoreboard, sampled on the falling clk edge
  initial begin
    spi_miso = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inf = 0;
        have_high = 0;
        spi_miso = 0;
        pf = 0;
        pd = 0;
      end else begin
        if (f_done) chk("f_done_width", pf, 0);
        if (d_done) chk("d_done_width", pd, 0);
        nf += int'(f_done && !pf);
        nd += int'(d_done && !pd);
        pf = f_done;
        pd = d_done;
        if (inf && spi_cs_rom_n && spi_cs_ram_n) begin
          inf = 0;
          t_high = cyc;
          have_high = 1;
          if (sb.size() == 0) chk("unexpected_frame", 1, 0);
          else begin
            e = sb.pop_front();
            chk("frame_bytes", bits, e.bytes);
            chk("bit_count", nb, 40);
            chk("cs_select", rom_sel, e.rom);
            chk("cs_stable", glitch, 0);
            chk("latency", cyc - t_grant, 82);
            chk("f_done", f_done, e.rom);
            chk("d_done", d_done, !e.rom);
            chk("rdata", rdata, e.rdata);
          end
        end else if (!inf && !(spi_cs_rom_n && spi_cs_ram_n)) begin
          inf = 1;
          t_grant = cyc;
          nb = 0;
          bits = 0;
          glitch = 0;
          rom_sel = !spi_cs_rom_n;
          chk("cs_exclusive", spi_cs_rom_n ^ spi_cs_ram_n, 1);
          if (have_high) chk("cs_gap_ge2", (cyc - t_high) >= 2, 1);
          if (sb.size() > 0) chk("setup_mosi", spi_mosi, sb[0].bytes[39]);
        end
        if (inf) begin
          if (spi_cs_rom_n != !rom_sel || spi_cs_ram_n != rom_sel) glitch = 1;
          if (spi_sclk) begin
            bits = {bits[38:0], spi_mosi};
            nb++;
          end else
            spi_miso = (nb >= 32 && nb < 40 && sb.size() > 0) ? sb[0].resp[39 - nb] : 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1;
    #1;
    chk("rst_cs_rom_n", spi_cs_rom_n, 1);
    chk("rst_cs_ram_n", spi_cs_ram_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_f_done", f_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    exp_f(16'h1234, 8'hA5);
    fetch(16'h1234);
    exp_d(1, 16'hBEEF, 8'h5C, 8'h3C);
    dacc(1, 16'hBEEF, 8'h5C);
    exp_d(0, 16'h0102, 8'h00, 8'h66);
    dacc(0, 16'h0102, 8'h00);
    // contention: both requests held from reset, fetch wins the first tie
    @(negedge clk);
    rst = 1;
    model_rd = 0;
    f_addr = 16'h1111;
    f_req = 1;
    d_we = 0;
    d_addr = 16'h2222;
    d_req = 1;
    exp_f(16'h1111, 8'h11);
    exp_d(0, 16'h2222, 8'h00, 8'h22);
    exp_f(16'h3333, 8'h33);
    exp_d(1, 16'h4444, 8'h4C, 8'h44);
    repeat (2) @(negedge clk);
    rst = 0;
    fork
      begin
        fetch(16'h1111);
        @(posedge clk);
        #1 fetch(16'h3333);
      end
      begin
        dacc(0, 16'h2222, 8'h00);
        @(posedge clk);
        #1 dacc(1, 16'h4444, 8'h4C);
      end
    join
    exp_f(16'h0040, 8'h5A);
    fork
      fetch(16'h0040);
      begin
        wait_cs_rom;
        repeat (20) @(negedge clk);
        f_addr = 16'hFFFF;
      end
    join
    exp_f(16'h0ABC, 8'hC3);
    fork
      fetch(16'h0ABC);
      begin
        wait_cs_rom;
        repeat (40) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("abort_cs_rom_n", spi_cs_rom_n, 1);
        chk("abort_cs_ram_n", spi_cs_ram_n, 1);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_f_done", f_done, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst = 0;
      end
    join
    repeat (4) @(negedge clk);
    chk("f_done_count", nf, 5);
    chk("d_done_count", nd, 4);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
